// File: rtl/seq_scan_ctrl_pkg.sv
// Shared definitions for the frame-level scan controller and its bench.
package seq_scan_ctrl_pkg;

    // Controller FSM encoding; all four codes are used.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Pattern recognised by the serial detector, first bit in the MSB.
    localparam logic [5:0] DET_PATTERN = 6'b110101;

endpackage

// File: rtl/seq_scan_ctrl_shift_reg.sv
// Loadable MSB-first left-shift register with its bit counter and last-bit flag.
module scan_shift_reg #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              shift_i,
    input  logic              count_i,
    output logic              msb_o,
    output logic [IDX_W-1:0]  bit_cnt_o,
    output logic              last_o
);

    logic [DATA_W-1:0] sr_q;
    logic [IDX_W-1:0]  cnt_q;

    // Load has priority; shifting and counting are separate so the first bit
    // can be presented before any bit has been sampled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            sr_q  <= data_i;
            cnt_q <= '0;
        end else begin
            if (shift_i) begin
                sr_q <= {sr_q[DATA_W-2:0], 1'b0};
            end
            if (count_i) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign msb_o     = sr_q[DATA_W-1];
    assign bit_cnt_o = cnt_q;
    assign last_o    = (cnt_q == IDX_W'(DATA_W - 1));

endmodule

// File: rtl/seq_scan_ctrl.sv
// Frame controller: clears the pattern detector, shifts one word through it
// MSB-first and reports the per-frame hit count and first-hit position.
module seq_scan_ctrl
    import seq_scan_ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 4,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              abort,
    output logic              det_rst_n,
    output logic              det_d_in,
    input  logic              det_hit,
    output logic              busy,
    output logic              result_valid,
    output logic [CNT_W-1:0]  hit_count,
    output logic              hit_any,
    output logic [IDX_W-1:0]  first_hit_idx
);

    state_e             state_q;
    logic               in_ready_q, busy_q, result_valid_q;
    logic               det_rst_n_q, det_d_in_q;
    logic [CNT_W-1:0]   hit_count_q, wcnt_q, wcnt_d;
    logic               hit_any_q, wany_q, wany_d;
    logic [IDX_W-1:0]   first_hit_idx_q, widx_q, widx_d;

    logic               accept;
    logic               sr_shift, sr_count;
    logic               sr_msb, sr_last;
    logic [IDX_W-1:0]   bit_cnt;

    assign accept   = (state_q == ST_IDLE) && in_valid && in_ready_q;
    // The first bit is presented at the end of CLEAR, so the register shifts
    // there too, but only sampled SHIFT cycles advance the bit counter.
    assign sr_shift = ((state_q == ST_CLEAR) || (state_q == ST_SHIFT)) && !abort;
    assign sr_count = (state_q == ST_SHIFT) && !abort;

    scan_shift_reg #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_shift (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (accept),
        .data_i    (in_data),
        .shift_i   (sr_shift),
        .count_i   (sr_count),
        .msb_o     (sr_msb),
        .bit_cnt_o (bit_cnt),
        .last_o    (sr_last)
    );

    // Working accumulator update for the bit presented this cycle.
    always_comb begin
        wcnt_d = wcnt_q;
        wany_d = wany_q | det_hit;
        widx_d = widx_q;
        if (det_hit && (wcnt_q != {CNT_W{1'b1}})) begin
            wcnt_d = wcnt_q + 1'b1;
        end
        if (det_hit && !wany_q) begin
            widx_d = bit_cnt;
        end
    end

    // Frame FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            in_ready_q      <= 1'b1;
            busy_q          <= 1'b0;
            result_valid_q  <= 1'b0;
            det_rst_n_q     <= 1'b1;
            det_d_in_q      <= 1'b0;
            hit_count_q     <= '0;
            hit_any_q       <= 1'b0;
            first_hit_idx_q <= '0;
            wcnt_q          <= '0;
            wany_q          <= 1'b0;
            widx_q          <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_ready_q     <= 1'b1;
                    busy_q         <= 1'b0;
                    result_valid_q <= 1'b0;
                    det_rst_n_q    <= 1'b1;
                    det_d_in_q     <= 1'b0;
                    if (accept) begin
                        state_q     <= ST_CLEAR;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        det_rst_n_q <= 1'b0;
                        wcnt_q      <= '0;
                        wany_q      <= 1'b0;
                        widx_q      <= '0;
                    end
                end
                ST_CLEAR: begin
                    det_rst_n_q <= 1'b1;
                    if (abort) begin
                        state_q    <= ST_IDLE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        det_d_in_q <= 1'b0;
                    end else begin
                        state_q    <= ST_SHIFT;
                        det_d_in_q <= sr_msb;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        state_q    <= ST_IDLE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        det_d_in_q <= 1'b0;
                    end else begin
                        wcnt_q <= wcnt_d;
                        wany_q <= wany_d;
                        widx_q <= widx_d;
                        if (sr_last) begin
                            // Results include the final bit's sample.
                            state_q         <= ST_DONE;
                            busy_q          <= 1'b0;
                            result_valid_q  <= 1'b1;
                            det_d_in_q      <= 1'b0;
                            hit_count_q     <= wcnt_d;
                            hit_any_q       <= wany_d;
                            first_hit_idx_q <= widx_d;
                        end else begin
                            det_d_in_q <= sr_msb;
                        end
                    end
                end
                ST_DONE: begin
                    state_q        <= ST_IDLE;
                    result_valid_q <= 1'b0;
                    in_ready_q     <= 1'b1;
                end
                default: begin
                    state_q         <= ST_IDLE;
                    in_ready_q      <= 1'b1;
                    busy_q          <= 1'b0;
                    result_valid_q  <= 1'b0;
                    det_rst_n_q     <= 1'b1;
                    det_d_in_q      <= 1'b0;
                    hit_count_q     <= '0;
                    hit_any_q       <= 1'b0;
                    first_hit_idx_q <= '0;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign busy          = busy_q;
    assign result_valid  = result_valid_q;
    assign det_rst_n     = det_rst_n_q;
    assign det_d_in      = det_d_in_q;
    assign hit_count     = hit_count_q;
    assign hit_any       = hit_any_q;
    assign first_hit_idx = first_hit_idx_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: two instances (CNT_W=4 and CNT_W=1) driven in
// lockstep, each with a behavioural pattern detector beside it.
module tb_seq_scan_ctrl;
    import seq_scan_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n, in_valid, abort;
    logic [15:0] in_data;
    logic [1:0]  in_ready, busy, result_valid, det_rst_n, det_d_in, det_hit, hit_any;
    logic [3:0]  hit_count0, idx0, idx1;
    logic [0:0]  hit_count1;

    int total = 0;
    int bad   = 0;
    int exp_cnt0, exp_cnt1, exp_any, exp_idx;

    always #5 clk = ~clk;

    seq_scan_ctrl #(.DATA_W(16), .CNT_W(4), .IDX_W(4)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_data(in_data), .abort(abort), .det_rst_n(det_rst_n[0]), .det_d_in(det_d_in[0]),
        .det_hit(det_hit[0]), .busy(busy[0]), .result_valid(result_valid[0]),
        .hit_count(hit_count0), .hit_any(hit_any[0]), .first_hit_idx(idx0));

    seq_scan_ctrl #(.DATA_W(16), .CNT_W(1), .IDX_W(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_data(in_data), .abort(abort), .det_rst_n(det_rst_n[1]), .det_d_in(det_d_in[1]),
        .det_hit(det_hit[1]), .busy(busy[1]), .result_valid(result_valid[1]),
        .hit_count(hit_count1), .hit_any(hit_any[1]), .first_hit_idx(idx1));

    // Behavioural detector: remembers the bits seen since its last reset or
    // match; a hit is the current bit completing the pattern.
    logic [4:0] hist [2];
    int         hlen [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!det_rst_n[k] || det_hit[k]) begin
                hlen[k] <= 0;
                hist[k] <= '0;
            end else begin
                hist[k] <= {hist[k][3:0], det_d_in[k]};
                hlen[k] <= (hlen[k] < 5) ? hlen[k] + 1 : 5;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            det_hit[k] = (hlen[k] >= 5) && (hist[k] == DET_PATTERN[5:1]) && det_d_in[k];
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
        end
    endtask

    // Reference: scan the word bit by bit; a hit is a 6-bit window equal to the
    // pattern lying entirely after the previous hit.
    function automatic void ref_frame(input logic [15:0] w, output int cnt,
                                      output int first, output logic [15:0] mask);
        int start;
        logic [5:0] win;
        start = 0; cnt = 0; first = -1; mask = '0;
        for (int i = 0; i < 16; i++) begin
            if (i - start >= 5) begin
                for (int j = 0; j < 6; j++) win[5-j] = w[15-(i-5+j)];
                if (win == DET_PATTERN) begin
                    cnt++;
                    mask[i] = 1'b1;
                    if (first < 0) first = i;
                    start = i + 1;
                end
            end
        end
    endfunction

    // Called at a negedge: waits (bounded) for in_ready, then offers a word
    // which is accepted at the following posedge.
    task automatic offer(input logic [15:0] w);
        int t;
        t = 0;
        while (!in_ready[0] && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready[0]) chk("ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
    endtask

    // Follows a frame accepted at the last posedge; cycle n is the n-th
    // negedge after acceptance. abort_at >= 0 aborts in that SHIFT cycle.
    task automatic observe(input logic [15:0] w, input int abort_at);
        int cnt, first, rst_lo;
        logic [15:0] mask, gmask, gword;
        bit aborted;
        ref_frame(w, cnt, first, mask);
        gmask = '0; gword = '0; rst_lo = 0; aborted = 1'b0;
        for (int n = 1; n <= 19; n++) begin
            @(negedge clk);
            if (n == 1) in_valid = 1'b0;
            abort = 1'b0;
            if (aborted) begin
                chk("abort_rv", result_valid[0], 0);
                chk("abort_busy", busy[0], 0);
                chk("abort_ready", in_ready[0], 1);
                chk("abort_detrst", det_rst_n[0], 1);
                chk("abort_cnt_hold", hit_count0, exp_cnt0);
                chk("abort_idx_hold", idx0, exp_idx);
                chk("abort_any_hold", hit_any[0], exp_any);
                return;
            end
            if (!det_rst_n[0]) rst_lo++;
            if (n == 1) begin
                chk("clear_busy", busy[0], 1);
                chk("clear_ready", in_ready[0], 0);
                chk("clear_detrst", det_rst_n[0], 0);
            end
            if (n >= 2 && n <= 17) begin
                gword[17-n] = det_d_in[0];
                gmask[n-2]  = det_hit[0];
            end
            if (n == 17) chk("rv_early", result_valid[0], 0);
            if (n == 18) begin
                exp_cnt0 = (cnt > 15) ? 15 : cnt;
                exp_cnt1 = (cnt > 1) ? 1 : cnt;
                exp_any  = (cnt > 0) ? 1 : 0;
                exp_idx  = (first < 0) ? 0 : first;
                chk("rv", result_valid[0], 1);
                chk("rv_w1", result_valid[1], 1);
                chk("done_busy", busy[0], 0);
                chk("hit_count", hit_count0, exp_cnt0);
                chk("hit_count_w1", hit_count1, exp_cnt1);
                chk("hit_any", hit_any[0], exp_any);
                chk("first_idx", idx0, exp_idx);
                chk("first_idx_w1", idx1, exp_idx);
                chk("shifted_word", gword, w);
                chk("hit_positions", gmask, mask);
                chk("clear_cycles", rst_lo, 1);
            end
            if (n == 19) begin
                chk("rv_pulse", result_valid[0], 0);
                chk("idle_ready", in_ready[0], 1);
            end
            if (abort_at >= 0 && n == abort_at + 2) begin
                abort   = 1'b1;
                aborted = 1'b1;
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, in_ready[0], 1);
        chk({tag, "_busy"}, busy[0], 0);
        chk({tag, "_rv"}, result_valid[0], 0);
        chk({tag, "_detrst"}, det_rst_n[0], 1);
        chk({tag, "_din"}, det_d_in[0], 0);
        chk({tag, "_cnt"}, hit_count0, 0);
        chk({tag, "_any"}, hit_any[0], 0);
        chk({tag, "_idx"}, idx0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        int p;
        reset_n = 1'b0; in_valid = 1'b0; abort = 1'b0; in_data = '0;
        exp_cnt0 = 0; exp_cnt1 = 0; exp_any = 0; exp_idx = 0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Directed frames, offered back to back.
        offer(16'hD400); observe(16'hD400, -1);
        offer(16'h001A); observe(16'h001A, -1);
        offer(16'h8000); observe(16'h8000, -1);
        offer(16'hD750); observe(16'hD750, -1);
        // Abort in the 4th SHIFT cycle, then the same word runs to completion.
        offer(16'hD400); observe(16'hD400, 3);
        offer(16'hD400); observe(16'hD400, -1);

        // Random words, half with the pattern planted at a random offset.
        for (int f = 0; f < 24; f++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                p = $urandom_range(0, 10);
                w[15-p -: 6] = DET_PATTERN;
            end
            offer(w);
            observe(w, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : -1);
        end

        // Reset in the middle of SHIFT, with a word already waiting.
        offer(16'hD750);
        repeat (6) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("midreset");
        exp_cnt0 = 0; exp_cnt1 = 0; exp_any = 0; exp_idx = 0;
        in_valid = 1'b1;
        in_data  = 16'hD400;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        observe(16'hD400, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
- Frame-level controller for the serial pattern detector instance (Mealy detector for "110101"; it restarts from its idle state after each match).
- Accepts one parallel word per frame via valid/ready, clears the detector, then shifts the word MSB-first into the detector's serial input.
- Samples the detector's Mealy hit output every shift cycle and reports per-frame hit count and first-hit position.
- Sits between the host-side word stream and the detector; only this block drives the detector's data and reset pins.

Parameters:
- DATA_W, 16: frame width in bits; one accepted word is one frame.
- CNT_W, 4: hit_count width; the count saturates at 2^CNT_W-1.
- IDX_W, 4: first_hit_idx width; must satisfy 2^IDX_W >= DATA_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  word offered.
- in_ready  out  1  block can accept a word.
- in_data  in  DATA_W  frame word; bit DATA_W-1 is shifted first.
- abort  in  1  synchronous abort of the frame in progress.
- det_rst_n  out  1  registered active-low clear to the detector's reset_n.
- det_d_in  out  1  registered serial bit to the detector's d_in.
- det_hit  in  1  detector's q_out; combinational, Mealy.
- busy  out  1  frame in progress (CLEAR or SHIFT).
- result_valid  out  1  one-cycle pulse when a frame completes.
- hit_count  out  CNT_W  hits in the last completed frame.
- hit_any  out  1  at least one hit in the last completed frame.
- first_hit_idx  out  IDX_W  bit index of the first hit; index 0 is the first bit shifted.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, reset_n).
- Reset values:
  - state=IDLE, in_ready=1, busy=0, result_valid=0.
  - det_rst_n=1, det_d_in=0.
  - hit_count=0, hit_any=0, first_hit_idx=0.
  - Shift register and bit counter cleared.
- IDLE:
  - in_ready=1, det_d_in=0.
  - On in_valid&in_ready at an edge: load the shift register with in_data, clear bit_cnt and the working counters, go to CLEAR.
  - Result outputs hold their last values.
- CLEAR (one cycle):
  - det_rst_n=0 and det_d_in=0, both registered; in_ready=0, busy=1.
  - Next state is SHIFT. At the edge ending this cycle the detector is still held in reset, so it starts SHIFT in its idle state.
- SHIFT (exactly DATA_W cycles):
  - det_rst_n=1; det_d_in = current shift-register MSB, registered so it is stable for the whole cycle.
  - Each cycle, sample det_hit together with the bit being presented:
    - If det_hit=1, increment the working count, saturating at 2^CNT_W-1.
    - On the first hit of the frame, latch bit_cnt into the working first index and set the working hit_any.
  - Shift left by one and increment bit_cnt.
  - After the cycle with bit_cnt=DATA_W-1, go to DONE.
- DONE (one cycle):
  - Copy the working registers to hit_count, hit_any and first_hit_idx.
  - result_valid=1, busy=0, det_d_in=0, in_ready=0.
  - Next state is IDLE.
- Latency: for a word accepted at edge E, CLEAR is cycle E+1, SHIFT is cycles E+2 .. E+1+DATA_W, and result_valid is high in cycle E+2+DATA_W. Throughput is one frame per DATA_W+3 cycles.
- Frame independence: every frame begins with CLEAR, so a pattern never spans two frames.
- abort:
  - When sampled high in CLEAR or SHIFT, the next state is IDLE.
  - No result_valid; result outputs keep the previous frame's values; working counters are discarded; det_rst_n returns to 1.
  - abort in IDLE or DONE is ignored. abort together with in_valid in IDLE: the word is accepted.
- first_hit_idx is 0 whenever hit_any=0.
- Saturation does not affect hit_any or first_hit_idx.
- Illegal or unused state encodings return to IDLE with all outputs at their reset values.
- Reset mid-frame: immediate return to reset values, including det_rst_n=1.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE, CLEAR, SHIFT, DONE; 2 bits).
  - The detector pattern constant 6'b110101, used as the reference in the bench.
- One natural sub-module, scan_shift_reg: a DATA_W loadable left-shift register with its bit counter and a last-bit flag.
- The FSM, the hit accumulator and the result registers stay in seq_scan_ctrl.
- The detector is instantiated beside this block at the top level, not inside it.

Test Plan:
- DATA_W=16: in_data=16'hD400 -> result_valid exactly 18 cycles after accept, hit_count=1, hit_any=1, first_hit_idx=5.
- in_data=16'hD750 (110101 110101 0000) -> hit_count=2, first_hit_idx=5; det_hit is seen high at bit indices 5 and 11 only.
- Back-to-back frames 16'h001A then 16'h8000 (a pattern straddling the boundary) -> both frames report hit_count=0, hit_any=0; det_rst_n is low for exactly one cycle before each frame's SHIFT.
- Override CNT_W=1 with in_data=16'hD750 -> hit_count=1 (saturated), first_hit_idx=5.
- Assert abort in the 4th SHIFT cycle of a 16'hD400 frame -> no result_valid; outputs keep the previous frame's values; in_ready=1 the next cycle; the following frame with 16'hD400 reports count 1.
- Assert reset_n=0 mid-SHIFT -> all outputs go to reset values immediately; in_valid held high is accepted after reset release.
